// File: rtl/lfsr_index_finder.sv
// lfsr_index_finder
//   Searches the 8-bit Fibonacci LFSR sequence for the first step index that
//   produces a given target value. The tap derivation and the sequence match
//   the companion generator: start from SEED, shift left, and feed back
//   lfsr[tap0] ^ lfsr[tap1] into bit 0.
//
// Ports
//   wb_clk_i   in   1  clock, rising edge
//   wb_rst_i   in   1  asynchronous active-high reset
//   start      in   1  search request, only honoured in IDLE
//   tap_mask   in   8  tap-select bits, latched when start is accepted
//   target     in   8  value to locate, latched when start is accepted
//   busy       out  1  high from LOAD through SEARCH
//   done       out  1  one-cycle pulse in DONE
//   found      out  1  result flag, valid from DONE until the next accept
//   index      out  8  step index of the first match, 8'hFF on a miss
//   tap0       out  3  tap index in use
//   tap1       out  3  tap index in use
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; inputs latched on the accepting edge
// LOAD   | seed the LFSR, clear counters, restore default taps
// TAPS   | 8 cycles, scan tap_mask bit i for the first two set bits
// SEARCH | compare lfsr with target, then step; give up after j==255
// DONE   | one-cycle done pulse, result already latched

module lfsr_index_finder #(
  parameter int                DWIDTH = 8,
  parameter logic [DWIDTH-1:0] SEED   = 8'h01
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start,
  input  logic [7:0]        tap_mask,
  input  logic [DWIDTH-1:0] target,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [7:0]        index,
  output logic [2:0]        tap0,
  output logic [2:0]        tap1
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_TAPS   = 3'd2;
  localparam logic [2:0] S_SEARCH = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        r_state;
  logic [7:0]        r_mask;
  logic [DWIDTH-1:0] r_target;
  logic [DWIDTH-1:0] r_lfsr;
  logic [7:0]        r_j;
  logic [2:0]        r_i;
  logic [1:0]        r_tap_cnt;
  logic [2:0]        r_tap0;
  logic [2:0]        r_tap1;
  logic              r_busy;
  logic              r_done;
  logic              r_found;
  logic [7:0]        r_index;
  logic              w_feedback;

  assign w_feedback = r_lfsr[r_tap0] ^ r_lfsr[r_tap1];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_target  <= '0;
      r_lfsr    <= SEED;
      r_j       <= '0;
      r_i       <= '0;
      r_tap_cnt <= '0;
      r_tap0    <= 3'd1;
      r_tap1    <= 3'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_found   <= 1'b0;
      r_index   <= 8'hFF;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_LOAD;
            r_mask   <= tap_mask;
            r_target <= target;
            r_found  <= 1'b0;
            r_index  <= 8'hFF;
            r_busy   <= 1'b1;
          end
        end
        S_LOAD: begin
          r_lfsr    <= SEED;
          r_j       <= '0;
          r_i       <= '0;
          r_tap0    <= 3'd1;
          r_tap1    <= 3'd0;
          r_tap_cnt <= '0;
          r_state   <= S_TAPS;
        end
        S_TAPS: begin
          // only the first two set bits select taps; later ones are ignored
          if (r_mask[r_i]) begin
            if (r_tap_cnt == 2'd0) begin
              r_tap0    <= r_i;
              r_tap_cnt <= 2'd1;
            end else if (r_tap_cnt == 2'd1) begin
              r_tap1    <= r_i;
              r_tap_cnt <= 2'd2;
            end
          end
          if (r_i == 3'd7) begin
            r_state <= S_SEARCH;
          end else begin
            r_i <= r_i + 3'd1;
          end
        end
        S_SEARCH: begin
          if (r_lfsr == r_target) begin
            r_index <= r_j;
            r_found <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_j == 8'hFF) begin
            // the j bound also covers a lock-up at all zeros
            r_index <= 8'hFF;
            r_found <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_lfsr <= {r_lfsr[DWIDTH-2:0], w_feedback};
            r_j    <= r_j + 8'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign found = r_found;
  assign index = r_index;
  assign tap0  = r_tap0;
  assign tap1  = r_tap1;

endmodule

// File: tb/tb_lfsr_index_finder.sv
// Self-checking bench for lfsr_index_finder: a cycle-level expectation model
// (driven by the spec's timing rules and a sequence-table search) is compared
// with the DUT outputs on every falling edge, plus literal spot checks.

module tb_lfsr_index_finder;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic       start    = 1'b0;
  logic [7:0] tap_mask = 8'h00;
  logic [7:0] target   = 8'h00;
  logic       busy;
  logic       done;
  logic       found;
  logic [7:0] index;
  logic [2:0] tap0;
  logic [2:0] tap1;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  lfsr_index_finder #(.DWIDTH(8), .SEED(8'h01)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .start    (start),
    .tap_mask (tap_mask),
    .target   (target),
    .busy     (busy),
    .done     (done),
    .found    (found),
    .index    (index),
    .tap0     (tap0),
    .tap1     (tap1)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Reference: derive taps from the mask, tabulate the whole 256-step
  // sequence, then pick the smallest index whose value equals the target.
  function automatic void model_search(input logic [7:0] m, input logic [7:0] t,
                                       output logic f, output logic [7:0] idx,
                                       output logic [2:0] t0, output logic [2:0] t1);
    logic [7:0] seq [256];
    int n;
    t0 = 3'd1; t1 = 3'd0; n = 0;
    for (int b = 0; b < 8; b++) begin
      if (m[b]) begin
        if (n == 0) t0 = 3'(b);
        else if (n == 1) t1 = 3'(b);
        n++;
      end
    end
    seq[0] = 8'h01;
    for (int k = 1; k < 256; k++) seq[k] = {seq[k-1][6:0], seq[k-1][t0] ^ seq[k-1][t1]};
    f = 1'b0; idx = 8'hFF;
    for (int k = 255; k >= 0; k--) begin
      if (seq[k] == t) begin f = 1'b1; idx = 8'(k); end
    end
  endfunction

  function automatic logic [7:0] seq_value(input logic [7:0] m, input int k);
    logic f; logic [7:0] idx; logic [2:0] t0, t1;
    logic [7:0] v;
    model_search(m, 8'h00, f, idx, t0, t1);
    v = 8'h01;
    for (int s = 0; s < k; s++) v = {v[6:0], v[t0] ^ v[t1]};
    return v;
  endfunction

  // Cycle-level model: m_cyc is the spec's cycle number (1 = LOAD) of the
  // current search; m_dc is the cycle in which done must be high.
  bit         m_active = 1'b0;
  int         m_cyc    = 0;
  int         m_dc     = 0;
  logic       m_found  = 1'b0;
  logic [7:0] m_index  = 8'hFF;
  logic [2:0] m_t0     = 3'd1;
  logic [2:0] m_t1     = 3'd0;
  logic       p_found;
  logic [7:0] p_index;
  logic [2:0] p_t0, p_t1;

  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      m_active = 1'b0; m_cyc = 0; m_dc = 0;
      m_found = 1'b0; m_index = 8'hFF; m_t0 = 3'd1; m_t1 = 3'd0;
    end else if ((!m_active || m_cyc > m_dc) && start) begin
      model_search(tap_mask, target, p_found, p_index, p_t0, p_t1);
      m_dc     = p_found ? 11 + int'(p_index) : 266;
      m_active = 1'b1;
      m_cyc    = 1;
      m_found  = 1'b0;
      m_index  = 8'hFF;
    end else if (m_active && m_cyc <= m_dc) begin
      m_cyc++;
      if (m_cyc == 10) begin m_t0 = p_t0; m_t1 = p_t1; end
      if (m_cyc == m_dc) begin m_found = p_found; m_index = p_index; end
    end
  end

  always @(negedge wb_clk_i) begin
    if (chk_on && !wb_rst_i) begin
      chk("busy",  int'(busy),  int'(m_active && m_cyc < m_dc));
      chk("done",  int'(done),  int'(m_active && m_cyc == m_dc));
      chk("found", int'(found), int'(m_found));
      chk("index", int'(index), int'(m_index));
      if (!m_active || m_cyc == 1 || m_cyc >= 10) begin
        chk("tap0", int'(tap0), int'(m_t0));
        chk("tap1", int'(tap1), int'(m_t1));
      end
    end
  end

  // Called at a falling edge with the DUT idle. Returns the cycle number in
  // which done was seen (0 on timeout). Optionally pulses start mid-search.
  task automatic run_search(input logic [7:0] m, input logic [7:0] t,
                            input int pulse_at, input logic [7:0] pulse_t,
                            output int dcyc);
    int c;
    tap_mask = m; target = t; start = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
    c = 1;
    while (!done && c < 400) begin
      @(negedge wb_clk_i);
      c++;
      if (pulse_at != 0 && c == pulse_at) begin start = 1'b1; target = pulse_t; end
      if (pulse_at != 0 && c == pulse_at + 1) begin start = 1'b0; target = t; end
    end
    if (!done) begin
      chk("done_timeout", 0, 1);
      dcyc = 0;
    end else begin
      dcyc = c;
    end
  endtask

  task automatic settle();
    @(negedge wb_clk_i);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int dc;
    int c;
    int dones;
    logic f; logic [7:0] idx; logic [2:0] t0, t1;
    logic [7:0] tgt;

    // pin the reference model against hand-computed results
    model_search(8'h03, 8'h0D, f, idx, t0, t1);
    chk("model_03_0D_idx", int'(idx), 3);
    chk("model_03_0D_taps", int'({t0, t1}), int'({3'd0, 3'd1}));
    model_search(8'h01, 8'h03, f, idx, t0, t1);
    chk("model_01_03_found", int'(f), 0);
    model_search(8'h94, 8'h00, f, idx, t0, t1);
    chk("model_94_taps", int'({t0, t1}), int'({3'd2, 3'd4}));

    repeat (3) @(negedge wb_clk_i);
    #2 wb_rst_i = 1'b0;
    chk_on = 1'b1;
    @(negedge wb_clk_i);
    chk("rst_index", int'(index), 8'hFF);
    chk("rst_taps", int'({tap0, tap1}), int'({3'd1, 3'd0}));

    run_search(8'h03, 8'h0D, 0, 8'h00, dc); settle();
    chk("m03_t0D_done_cycle", dc, 14);
    chk("m03_t0D_index", int'(index), 3);
    chk("m03_t0D_found", int'(found), 1);
    chk("m03_t0D_taps", int'({tap0, tap1}), int'({3'd0, 3'd1}));

    run_search(8'h03, 8'h01, 0, 8'h00, dc); settle();
    chk("m03_t01_done_cycle", dc, 11);
    chk("m03_t01_index", int'(index), 0);
    chk("m03_t01_found", int'(found), 1);

    run_search(8'h00, 8'h06, 0, 8'h00, dc); settle();
    chk("m00_t06_index", int'(index), 2);
    chk("m00_t06_found", int'(found), 1);
    chk("m00_t06_taps", int'({tap0, tap1}), int'({3'd1, 3'd0}));

    run_search(8'h01, 8'h80, 0, 8'h00, dc); settle();
    chk("m01_t80_index", int'(index), 7);
    chk("m01_t80_taps", int'({tap0, tap1}), int'({3'd0, 3'd0}));

    run_search(8'h01, 8'h03, 0, 8'h00, dc); settle();
    chk("m01_t03_done_cycle", dc, 266);
    chk("m01_t03_found", int'(found), 0);
    chk("m01_t03_index", int'(index), 8'hFF);

    // mid-search start pulse with a different target must be ignored
    tgt = seq_value(8'h94, 20);
    model_search(8'h94, tgt, f, idx, t0, t1);
    run_search(8'h94, tgt, 13, seq_value(8'h94, 1), dc); settle();
    chk("m94_pulse_index", int'(index), int'(idx));
    chk("m94_pulse_done_cycle", dc, 11 + int'(idx));
    chk("m94_taps", int'({tap0, tap1}), int'({3'd2, 3'd4}));

    // start held through DONE: second search with fresh latches
    tap_mask = 8'h94; target = tgt; start = 1'b1;
    @(negedge wb_clk_i);
    tap_mask = 8'h03; target = 8'h0D;
    c = 1;
    while (!done && c < 400) begin @(negedge wb_clk_i); c++; end
    chk("b2b_first_done", int'(done), 1);
    chk("b2b_first_index", int'(index), int'(idx));
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    start = 1'b0;
    chk("b2b_cleared_found", int'(found), 0);
    chk("b2b_cleared_index", int'(index), 8'hFF);
    chk("b2b_busy", int'(busy), 1);
    c = 1;
    while (!done && c < 400) begin @(negedge wb_clk_i); c++; end
    chk("b2b_second_done_cycle", c, 14);
    chk("b2b_second_index", int'(index), 3);
    settle();
    chk("b2b_second_taps", int'({tap0, tap1}), int'({3'd0, 3'd1}));

    // reset mid-search
    tap_mask = 8'h01; target = 8'h03; start = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
    repeat (40) @(negedge wb_clk_i);
    chk("pre_rst_busy", int'(busy), 1);
    #2 wb_rst_i = 1'b1;
    #1;
    chk("rst_async_busy", int'(busy), 0);
    repeat (3) @(negedge wb_clk_i);
    #2 wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_found", int'(found), 0);
    chk("post_rst_index", int'(index), 8'hFF);
    chk("post_rst_taps", int'({tap0, tap1}), int'({3'd1, 3'd0}));
    dones = 0;
    repeat (300) begin @(negedge wb_clk_i); if (done) dones++; end
    chk("post_rst_no_done", dones, 0);
    run_search(8'h03, 8'h0D, 0, 8'h00, dc); settle();
    chk("post_rst_run_index", int'(index), 3);
    chk("post_rst_run_cycle", dc, 14);

    // randomized searches, mostly hits drawn from the sequence itself
    for (int n = 0; n < 24; n++) begin
      logic [7:0] rm;
      rm = 8'($urandom);
      if ($urandom_range(0, 3) == 0) tgt = 8'($urandom);
      else tgt = seq_value(rm, int'($urandom_range(0, 60)));
      run_search(rm, tgt, 0, 8'h00, dc); settle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_index_finder.md
# lfsr_index_finder

Inverse companion to the 8-bit Fibonacci LFSR number generator. The generator turns a tap mask and a step count into a pseudo-random number. This block takes a tap mask and a target number and searches the same sequence, from the same seed, for the first step index that produces the target. It sits beside the generator in the user area with the same clock. Software or the bench uses it to check or invert generator output.

## Interface
- `DWIDTH`, default 8: LFSR and target width. Only 8 is supported.
- `SEED`, default 8'h01: LFSR value at index 0.
- `wb_clk_i`, in, 1: sole clock. All logic is rising-edge.
- `wb_rst_i`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: request a search. Sampled only in IDLE.
- `tap_mask`, in, 8: tap-select bits. Sampled on the accepted start edge.
- `target`, in, 8: value to locate. Sampled on the accepted start edge.
- `busy`, out, 1: high from LOAD through SEARCH.
- `done`, out, 1: one-cycle pulse in DONE.
- `found`, out, 1: result flag. Valid from DONE until the next accepted start.
- `index`, out, 8: step index of the first match, or 8'hFF when not found.
- `tap0`, out, 3: tap index in use.
- `tap1`, out, 3: tap index in use.

## Operation
- States: IDLE, LOAD, TAPS, SEARCH, DONE. An undefined encoding goes to IDLE.
- IDLE:
  - On `start`=1 at a clock edge, go to LOAD.
  - `tap_mask` and `target` are latched on that same edge.
- LOAD (1 cycle):
  - lfsr<=SEED, j<=0, i<=0.
  - tap0<=1, tap1<=0 (the defaults).
  - Tap-found count cleared.
- TAPS (exactly 8 cycles, i=0..7):
  - Each cycle examines mask bit i.
  - First set bit found: tap0<=i.
  - Second set bit found: tap1<=i.
  - Later set bits are ignored.
  - Leave when i==7.
- Tap selection results:
  - No bits set: tap0=1, tap1=0.
  - One bit set: tap0 = that bit, tap1 stays 0.
- SEARCH, one comparison per cycle:
  - If lfsr==target: latch index<=j, found<=1, go to DONE.
  - Else if j==255: latch index<=8'hFF, found<=0, go to DONE.
  - Else: lfsr<={lfsr[6:0], lfsr[tap0]^lfsr[tap1]} and j<=j+1. j is 8-bit and never wraps.
- Result is always the smallest index.
  - 256 indices (0..255) are checked.
  - A lock-up at 0x00 is handled by the j bound. No special case is needed.
- DONE (1 cycle): `done`=1, then go to IDLE.
- `start` while not in IDLE is ignored and not queued.
- `start` held high in IDLE right after DONE starts a new search.
  - `found` and `index` clear to 0 and 8'hFF on that accept edge.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `found`=0, `index`=8'hFF, `tap0`=1, `tap1`=0.
- Reset mid-search aborts immediately to these values. No `done` is issued.
- Let edge 0 be the edge that accepts `start`.
  - LOAD occupies cycle 1.
  - TAPS occupies cycles 2-9.
  - SEARCH compares index k in cycle 10+k.
- `done` is high in cycle 11+k for a match at index k. This is 11 cycles minimum.
- A miss gives `done` in cycle 266.
- `busy` rises in cycle 1 and falls at the start of DONE.
- `done` and `busy` are never high together.
- All outputs are registered. `tap0`/`tap1` are final from cycle 10.

## Test plan
- **Reset checks.** Assert reset mid-SEARCH, then release:
  - all outputs return to their reset values;
  - no `done` pulse;
  - a following start runs normally.
- **Mask 8'h03, target 8'h0D.**
  - Sequence is 01, 03, 06, 0D.
  - Required: tap0=0, tap1=1, `done` in cycle 14, `found`=1, `index`=3.
- **Mask 8'h03, target 8'h01.**
  - Required: `done` in cycle 11, `index`=0, `found`=1.
- **Mask 8'h00 (defaults), target 8'h06.**
  - Required: tap0=1, tap1=0, `index`=2, `found`=1.
- **Mask 8'h01, sequence 1, 2, 4, …, 80, 00.**
  - Target 8'h80: tap0=0, tap1=0, `index`=7.
  - Target 8'h03: `found`=0, `index`=8'hFF, `done` in cycle 266.
- **Mask 8'h94, and start pulsed mid-search.**
  - Mask 8'h94 requires tap0=2, tap1=4. Bit 7 is ignored.
  - A `start` pulse mid-search with a different target is ignored. The original result is reported.
  - A back-to-back start held through DONE begins a second search with fresh latches.
